// File: rtl/axi_pkg.sv
// Shared AXI4 widths, encodings and payload types for the read-channel memory slave.
package axi_pkg;

    localparam int unsigned AXI_IW     = 4;
    localparam int unsigned AXI_AW     = 32;
    localparam int unsigned AXI_DW     = 32;
    localparam int unsigned AXI_LW     = 8;
    localparam int unsigned AXI_SW     = 3;
    localparam int unsigned AXI_BURSTW = 2;
    localparam int unsigned AXI_RRESPW = 2;

    // log2 of the data-bus width in bytes; also the word-address offset
    localparam int unsigned AXI_BYTE_LSB = $clog2(AXI_DW / 8);

    typedef enum logic [AXI_BURSTW-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    localparam logic [AXI_RRESPW-1:0] RRESP_OKAY   = 2'd0;
    localparam logic [AXI_RRESPW-1:0] RRESP_SLVERR = 2'd2;

    // axi_rd_mem FSM encoding
    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;

    typedef struct packed {
        logic [AXI_DW-1:0]     data;
        logic [AXI_RRESPW-1:0] resp;
        logic                  last;
    } rd_beat_t;

endpackage

// File: rtl/axi_rd_mem_if.sv
// AXI4 read address and read data channels.
interface axi_rd_mem_if;
    import axi_pkg::*;

    logic [AXI_IW-1:0]     ARID;
    logic [AXI_AW-1:0]     ARADDR;
    logic [AXI_LW-1:0]     ARLEN;
    logic [AXI_SW-1:0]     ARSIZE;
    logic [AXI_BURSTW-1:0] ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [AXI_IW-1:0]     RID;
    logic [AXI_DW-1:0]     RDATA;
    logic [AXI_RRESPW-1:0] RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry R-beat buffer; an incoming beat falls straight through to the output when empty.
module axi_rd_skid_fifo
    import axi_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  rd_beat_t in_beat,
    input  logic     out_ready,
    output logic     out_valid,
    output rd_beat_t out_beat,
    output logic [1:0] count
);

    rd_beat_t e0;
    rd_beat_t e1;
    logic     pop;

    assign out_valid = (count != 2'd0) || in_valid;
    assign pop       = out_valid && out_ready;

    // Head entry first; otherwise bypass the arriving beat; idle output is all zero
    always_comb begin
        out_beat = '0;
        if (count != 2'd0) begin
            out_beat = e0;
        end else if (in_valid) begin
            out_beat = in_beat;
        end
    end

    // e0 is always the head; a push while full is prevented by the issuer
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid && !pop) begin
                        e0    <= in_beat;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        e0 <= in_beat;
                    end else if (in_valid) begin
                        e1    <= in_beat;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        e0 <= e1;
                        if (in_valid) begin
                            e1 <= in_beat;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_mem.sv
// AXI4 read slave: expands one AR burst at a time into SRAM reads and returns beats on R.
module axi_rd_mem
    import axi_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi_rd_mem_if.slave       axi,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [AXI_DW-1:0] mem_rdata
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [AXI_IW-1:0]     id;
    logic [AXI_AW-1:0]     addr;
    logic [AXI_AW-1:0]     addr_nxt;
    logic [AXI_LW-1:0]     len;
    logic [AXI_LW-1:0]     cnt;
    logic [AXI_SW-1:0]     size;
    logic [AXI_BURSTW-1:0] burst;
    logic                  err;
    logic                  ar_err;
    logic                  ar_hs;
    logic                  pend_valid;
    logic                  pend_last;
    logic                  pend_err;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  pop;
    logic                  issue;
    logic                  r_valid;
    rd_beat_t              push_beat;
    rd_beat_t              r_beat;
    logic [AXI_AW-1:0]     bytes;
    logic [AXI_AW-1:0]     aligned;
    logic [AXI_AW-1:0]     wrap_mask;

    assign axi.ARREADY = (state == RD_IDLE) && !ARESET;
    assign ar_hs       = axi.ARVALID && axi.ARREADY;

    assign ar_err = (axi.ARBURST == 2'd3)
                 || (32'(axi.ARSIZE) > AXI_BYTE_LSB)
                 || ((axi.ARBURST == BURST_WRAP)
                     && !((axi.ARLEN == AXI_LW'(1)) || (axi.ARLEN == AXI_LW'(3))
                       || (axi.ARLEN == AXI_LW'(7)) || (axi.ARLEN == AXI_LW'(15))));

    // Buffered + pending beats after this cycle's pop must leave room for one more
    assign pop   = r_valid && axi.RREADY;
    assign occ   = 3'(count) + 3'(pend_valid) - 3'(pop);
    assign issue = (state == RD_BURST) && (occ < 3'd2) && !ARESET;

    assign mem_en   = issue && !err;
    assign mem_addr = addr[MEM_AW+AXI_BYTE_LSB-1:AXI_BYTE_LSB];

    assign bytes     = AXI_AW'(1) << size;
    assign aligned   = addr & ~(bytes - AXI_AW'(1));
    assign wrap_mask = ((AXI_AW'(len) + AXI_AW'(1)) << size) - AXI_AW'(1);

    // Address of the beat after the current one
    always_comb begin
        addr_nxt = aligned + bytes;
        if (burst == BURST_FIXED) begin
            addr_nxt = addr;
        end else if (burst == BURST_WRAP) begin
            addr_nxt = (addr & ~wrap_mask) | ((aligned + bytes) & wrap_mask);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:  if (ar_hs) state_nxt = RD_BURST;
            RD_BURST: if (issue && (cnt == len)) state_nxt = RD_DRAIN;
            RD_DRAIN: if (pop && r_beat.last) state_nxt = RD_IDLE;
            default:  state_nxt = RD_IDLE;
        endcase
    end

    // Burst context and the one-deep read pipeline tracking data due next cycle
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id         <= '0;
            addr       <= '0;
            len        <= '0;
            cnt        <= '0;
            size       <= '0;
            burst      <= '0;
            err        <= 1'b0;
            pend_valid <= 1'b0;
            pend_last  <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= issue;
            pend_last  <= issue && (cnt == len);
            pend_err   <= err;
            if (ar_hs) begin
                id    <= axi.ARID;
                addr  <= axi.ARADDR;
                len   <= axi.ARLEN;
                size  <= axi.ARSIZE;
                burst <= axi.ARBURST;
                err   <= ar_err;
                cnt   <= '0;
            end else if (issue) begin
                addr <= addr_nxt;
                cnt  <= cnt + AXI_LW'(1);
            end
        end
    end

    assign push_beat.data = pend_err ? '0 : mem_rdata;
    assign push_beat.resp = pend_err ? RRESP_SLVERR : RRESP_OKAY;
    assign push_beat.last = pend_last;

    axi_rd_skid_fifo u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .in_valid  (pend_valid),
        .in_beat   (push_beat),
        .out_ready (axi.RREADY),
        .out_valid (r_valid),
        .out_beat  (r_beat),
        .count     (count)
    );

    assign axi.RVALID = r_valid;
    assign axi.RDATA  = r_beat.data;
    assign axi.RRESP  = r_beat.resp;
    assign axi.RLAST  = r_beat.last;
    assign axi.RID    = id;

endmodule

// File: tb/tb_axi_rd_mem.sv
// Directed bench for axi_rd_mem with a behavioural SRAM holding 0xA000_0000 + word index.
module tb_axi_rd_mem;
    import axi_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];
    logic [31:0] exp_q[$];
    int          vectors;
    int          miscompares;

    axi_rd_mem_if axi();

    axi_rd_mem #(.MEM_AW(10)) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .axi       (axi),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        axi.ARID    = id;
        axi.ARADDR  = addr;
        axi.ARLEN   = len;
        axi.ARSIZE  = size;
        axi.ARBURST = burst;
        axi.ARVALID = 1'b1;
    endtask

    // Runs one burst; exp_q holds the expected RDATA per beat
    task automatic run_burst(input string name, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp, input logic toggle);
        int          n;
        int          issued;
        int          hs;
        int          max_out;
        logic        mem_seen;
        logic        stable_ok;
        logic        prev_stall;
        logic [38:0] prev_pay;
        logic [38:0] pay;
        n = 0; issued = 0; hs = 0; max_out = 0;
        mem_seen = 1'b0; stable_ok = 1'b1; prev_stall = 1'b0; prev_pay = '0;

        @(negedge clk);
        drive_ar(id, addr, len, size, burst);
        axi.RREADY = !toggle;
        #1;
        chk({name, "_arready_T"}, 64'(axi.ARREADY), 64'd1);

        @(negedge clk);
        axi.ARVALID = 1'b0;
        #1;
        chk({name, "_arready_T1"}, 64'(axi.ARREADY), 64'd0);
        chk({name, "_rvalid_T1"}, 64'(axi.RVALID), 64'd0);
        if (exp_resp == RRESP_OKAY) chk({name, "_mem_en_T1"}, 64'(mem_en), 64'd1);
        if (mem_en) begin
            issued++;
            mem_seen = 1'b1;
        end

        for (int cyc = 0; cyc < 64 && n <= int'(len); cyc++) begin
            @(negedge clk);
            axi.RREADY = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (mem_en) begin
                issued++;
                mem_seen = 1'b1;
            end
            pay = {axi.RVALID, axi.RID, axi.RDATA, axi.RLAST, axi.RRESP};
            if (prev_stall && (pay !== prev_pay)) stable_ok = 1'b0;
            if (axi.RVALID && axi.RREADY) begin
                hs++;
                if (n < exp_q.size()) begin
                    chk($sformatf("%s_rdata%0d", name, n), 64'(axi.RDATA), 64'(exp_q[n]));
                    chk($sformatf("%s_rresp%0d", name, n), 64'(axi.RRESP), 64'(exp_resp));
                    chk($sformatf("%s_rlast%0d", name, n), 64'(axi.RLAST), 64'(n == int'(len)));
                    chk($sformatf("%s_rid%0d", name, n), 64'(axi.RID), 64'(id));
                    if (!toggle) chk($sformatf("%s_cycle%0d", name, n), 64'(cyc), 64'(n));
                end
                n++;
            end
            if (issued - hs > max_out) max_out = issued - hs;
            prev_stall = axi.RVALID && !axi.RREADY;
            prev_pay   = pay;
        end

        chk({name, "_beats"}, 64'(n), 64'(int'(len) + 1));
        if (exp_resp == RRESP_OKAY) chk({name, "_outstanding_le2"}, 64'(max_out <= 2), 64'd1);
        else chk({name, "_mem_en_seen"}, 64'(mem_seen), 64'd0);
        if (toggle) chk({name, "_stall_stable"}, 64'(stable_ok), 64'd1);

        @(negedge clk);
        #1;
        chk({name, "_arready_after"}, 64'(axi.ARREADY), 64'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + 32'(k);
        mem_rdata   = '0;
        rst         = 1'b1;
        axi.ARVALID = 1'b0;
        axi.ARID    = '0;
        axi.ARADDR  = '0;
        axi.ARLEN   = '0;
        axi.ARSIZE  = '0;
        axi.ARBURST = '0;
        axi.RREADY  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_arready", 64'(axi.ARREADY), 64'd0);
        chk("rst_rvalid", 64'(axi.RVALID), 64'd0);
        chk("rst_rlast", 64'(axi.RLAST), 64'd0);
        chk("rst_rid", 64'(axi.RID), 64'd0);
        chk("rst_rdata", 64'(axi.RDATA), 64'd0);
        chk("rst_rresp", 64'(axi.RRESP), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_arready", 64'(axi.ARREADY), 64'd1);

        exp_q = '{32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
        run_burst("incr", 4'd5, 32'h10, 8'd3, 3'd2, 2'd1, RRESP_OKAY, 1'b0);

        exp_q = '{32'hA000_000E, 32'hA000_000F, 32'hA000_000C, 32'hA000_000D};
        run_burst("wrap", 4'd2, 32'h38, 8'd3, 3'd2, 2'd2, RRESP_OKAY, 1'b0);

        exp_q = '{32'hA000_0008, 32'hA000_0008, 32'hA000_0008};
        run_burst("fixed", 4'd9, 32'h20, 8'd2, 3'd2, 2'd0, RRESP_OKAY, 1'b0);

        exp_q = '{32'hA000_0040, 32'hA000_0041, 32'hA000_0042, 32'hA000_0043,
                  32'hA000_0044, 32'hA000_0045, 32'hA000_0046, 32'hA000_0047};
        run_burst("incr_bp", 4'd3, 32'h100, 8'd7, 3'd2, 2'd1, RRESP_OKAY, 1'b1);

        exp_q = '{32'h0, 32'h0, 32'h0};
        run_burst("err_wrap", 4'd6, 32'h0, 8'd2, 3'd2, 2'd2, RRESP_SLVERR, 1'b0);

        exp_q = '{32'h0, 32'h0};
        run_burst("err_size", 4'd1, 32'h40, 8'd1, 3'd3, 2'd1, RRESP_SLVERR, 1'b0);

        // Reset in the middle of an INCR burst, after beat 1 is taken
        @(negedge clk);
        drive_ar(4'd7, 32'h0, 8'd7, 3'd2, 2'd1);
        axi.RREADY = 1'b1;
        @(negedge clk);
        axi.ARVALID = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_beat1", 64'(axi.RDATA), 64'hA000_0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rvalid", 64'(axi.RVALID), 64'd0);
        chk("mid_rlast", 64'(axi.RLAST), 64'd0);
        chk("mid_arready", 64'(axi.ARREADY), 64'd1);

        exp_q = '{32'hA000_0000};
        run_burst("len0", 4'd4, 32'h0, 8'd0, 3'd2, 2'd1, RRESP_OKAY, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
